debounce_sync: RTL and testbench

DEBOUNCE_SYNC -- requirements
Module: debounce_sync

---
 rtl/debounce_pkg.sv | 17 +
 rtl/sync_2ff.sv | 31 +++
 rtl/debounce_sync.sv | 125 ++++++++++++
 tb/tb_debounce_sync.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and defaults for the debounce/synchronizer block
//
// Purpose : state encoding of the debounce FSM and the default qualification length.
// Contents: state_t (LOW, LOW_CHK, HIGH, HIGH_CHK), DEBOUNCE_CYCLES_DEF.

package debounce_pkg;

   localparam int DEBOUNCE_CYCLES_DEF = 4;

   typedef enum logic [1:0] {
      LOW      = 2'b00,
      LOW_CHK  = 2'b01,
      HIGH     = 2'b10,
      HIGH_CHK = 2'b11
   } state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level
//
// Purpose : bring an asynchronous level into the clk domain.
// Ports   : clk - clock, rising edge
//           rst - asynchronous active-low reset, clears both flops
//           d   - asynchronous input level
//           q   - synchronized level (second flop output)

module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchronizing debouncer with edge pulses
//
// Purpose : accept a new level of din only after DEBOUNCE_CYCLES consecutive
//           synchronized samples agree; report accepted edges as pulses.
// Ports   : clk  - clock, rising edge
//           rst  - asynchronous active-low reset
//           din  - raw asynchronous level, may bounce
//           dout - debounced level, decoded from the state register
//           rise - one-cycle pulse when dout goes 0->1
//           fall - one-cycle pulse when dout goes 1->0
//           busy - a candidate level change is being qualified

module debounce_sync
   import debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

   logic             w_din_s;
   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_rise;
   logic             r_fall;
   logic             w_rise_nxt;
   logic             w_fall_nxt;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (din),
      .q   (w_din_s)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= LOW;
         r_cnt   <= '0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
      end
   end

   // The first differing sample already counts as one, so the exit fires on
   // the sample that sees cnt == DEBOUNCE_CYCLES-1: the counter never reaches
   // DEBOUNCE_CYCLES and cannot wrap.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      case (r_state)
         LOW: begin
            if (w_din_s) begin
               w_state_nxt = LOW_CHK;
               w_cnt_nxt   = LP_CNT_ONE;
            end else begin
               w_cnt_nxt = '0;
            end
         end
         LOW_CHK: begin
            if (!w_din_s) begin
               w_state_nxt = LOW;
               w_cnt_nxt   = '0;
            end else if (r_cnt == LP_CNT_LAST) begin
               w_state_nxt = HIGH;
               w_cnt_nxt   = '0;
               w_rise_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + LP_CNT_ONE;
            end
         end
         HIGH: begin
            if (!w_din_s) begin
               w_state_nxt = HIGH_CHK;
               w_cnt_nxt   = LP_CNT_ONE;
            end else begin
               w_cnt_nxt = '0;
            end
         end
         HIGH_CHK: begin
            if (w_din_s) begin
               w_state_nxt = HIGH;
               w_cnt_nxt   = '0;
            end else if (r_cnt == LP_CNT_LAST) begin
               w_state_nxt = LOW;
               w_cnt_nxt   = '0;
               w_fall_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + LP_CNT_ONE;
            end
         end
         default: begin
            w_state_nxt = LOW;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Decoded from the state register only, so reset clears them at once and
   // there is no combinational path from din.
   assign dout = (r_state == HIGH) || (r_state == HIGH_CHK);
   assign busy = (r_state == LOW_CHK) || (r_state == HIGH_CHK);
   assign rise = r_rise;
   assign fall = r_fall;

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - randomized self-checking bench for debounce_sync

module tb_debounce_sync;

   localparam int N0 = 2;
   localparam int N1 = 4;
   localparam int N2 = 255;

   logic       clk;
   logic       rst;
   logic       din;
   logic [2:0] dout;
   logic [2:0] rise;
   logic [2:0] fall;
   logic [2:0] busy;

   int n_checks;
   int n_fail;

   int NS [3];

   // reference model state
   logic         dq    [$];
   logic [255:0] m_sh  [3];
   logic         m_dout[3];
   logic         m_rise[3];
   logic         m_fall[3];
   logic         m_busy[3];
   logic         p_dout[3];
   logic         p_rise[3];
   logic         p_fall[3];

   int lat  [3];
   int pcnt [3];

   debounce_sync #(.DEBOUNCE_CYCLES(N0)) u_dut0 (
      .clk(clk), .rst(rst), .din(din),
      .dout(dout[0]), .rise(rise[0]), .fall(fall[0]), .busy(busy[0]));
   debounce_sync #(.DEBOUNCE_CYCLES(N1)) u_dut1 (
      .clk(clk), .rst(rst), .din(din),
      .dout(dout[1]), .rise(rise[1]), .fall(fall[1]), .busy(busy[1]));
   debounce_sync #(.DEBOUNCE_CYCLES(N2)) u_dut2 (
      .clk(clk), .rst(rst), .din(din),
      .dout(dout[2]), .rise(rise[2]), .fall(fall[2]), .busy(busy[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      dq.delete();
      dq.push_back(1'b0);
      dq.push_back(1'b0);
      for (int i = 0; i < 3; i++) begin
         m_sh[i]   = '0;
         m_dout[i] = 1'b0;
         m_rise[i] = 1'b0;
         m_fall[i] = 1'b0;
         m_busy[i] = 1'b0;
      end
   endtask

   // A level is accepted once the last N synchronized samples all disagree
   // with the current output; the synchronizer is a two-sample delay line.
   task automatic model_step();
      logic ds;
      logic opp;
      ds = dq.pop_front();
      dq.push_back(din);
      for (int i = 0; i < 3; i++) begin
         m_rise[i] = 1'b0;
         m_fall[i] = 1'b0;
         m_sh[i]   = {m_sh[i][254:0], ds};
         opp = 1'b1;
         for (int j = 0; j < NS[i]; j++)
            if (m_sh[i][j] == m_dout[i]) opp = 1'b0;
         if (opp) begin
            if (m_dout[i]) m_fall[i] = 1'b1;
            else           m_rise[i] = 1'b1;
            m_dout[i] = ~m_dout[i];
         end
         m_busy[i] = (m_sh[i][0] != m_dout[i]);
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("dout[N=%0d]", NS[i]), 32'(dout[i]), 32'(m_dout[i]));
         check($sformatf("rise[N=%0d]", NS[i]), 32'(rise[i]), 32'(m_rise[i]));
         check($sformatf("fall[N=%0d]", NS[i]), 32'(fall[i]), 32'(m_fall[i]));
         check($sformatf("busy[N=%0d]", NS[i]), 32'(busy[i]), 32'(m_busy[i]));
         check($sformatf("rise_and_fall[N=%0d]", NS[i]), 32'(rise[i] & fall[i]), 32'd0);
         check($sformatf("rise_no_edge[N=%0d]", NS[i]),
               32'(rise[i] & ~(dout[i] & ~p_dout[i])), 32'd0);
         check($sformatf("fall_no_edge[N=%0d]", NS[i]),
               32'(fall[i] & ~(~dout[i] & p_dout[i])), 32'd0);
         check($sformatf("pulse_width[N=%0d]", NS[i]),
               32'((rise[i] & p_rise[i]) | (fall[i] & p_fall[i])), 32'd0);
         p_dout[i] = dout[i];
         p_rise[i] = rise[i];
         p_fall[i] = fall[i];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_step();
      else     model_reset();
      #1;
      compare_all();
   endtask

   task automatic drive(input logic v, input int n);
      din = v;
      repeat (n) tick();
   endtask

   // Edge 1 of the window is the capture edge k; latency counts edges after k.
   task automatic measure(input logic want_rise, input string tag);
      for (int i = 0; i < 3; i++) begin
         lat[i]  = -1;
         pcnt[i] = 0;
      end
      for (int t = 1; t <= 300; t++) begin
         tick();
         for (int i = 0; i < 3; i++) begin
            if (want_rise ? rise[i] : fall[i]) begin
               pcnt[i]++;
               if (lat[i] < 0) lat[i] = t - 1;
            end
         end
      end
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s_latency[N=%0d]", tag, NS[i]), 32'(lat[i]), 32'(NS[i] + 1));
         check($sformatf("%s_pulses[N=%0d]", tag, NS[i]), 32'(pcnt[i]), 32'd1);
      end
   endtask

   initial begin
      int cnt;
      int len;
      logic v;
      n_checks = 0;
      n_fail   = 0;
      NS[0] = N0;
      NS[1] = N1;
      NS[2] = N2;
      for (int i = 0; i < 3; i++) begin
         p_dout[i] = 1'b0;
         p_rise[i] = 1'b0;
         p_fall[i] = 1'b0;
      end
      rst = 1'b0;
      din = 1'b0;
      model_reset();

      // reset state, checked between edges
      #12;
      check("reset_dout", 32'(dout), 32'd0);
      check("reset_rise", 32'(rise), 32'd0);
      check("reset_fall", 32'(fall), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(1'b0, 5);

      // clean press and release, all three parameter values in parallel
      din = 1'b1;
      measure(1'b1, "press");
      din = 1'b0;
      measure(1'b0, "release");

      // short bounce must not disturb the N=4 output
      cnt = 0;
      din = 1'b1;
      for (int t = 0; t < 16; t++) begin
         if (t == 2) din = 1'b0;
         if (t == 3) din = 1'b1;
         if (t == 6) din = 1'b0;
         tick();
         cnt += int'(rise[1]) + int'(fall[1]) + int'(dout[1]);
      end
      check("bounce_activity[N=4]", 32'(cnt), 32'd0);

      // 254-sample glitch on the N=255 instance
      drive(1'b0, 300);
      cnt = 0;
      din = 1'b1;
      for (int t = 0; t < 254 + 260; t++) begin
         if (t == 254) din = 1'b0;
         tick();
         cnt += int'(rise[2]) + int'(fall[2]);
      end
      check("glitch254_pulses[N=255]", 32'(cnt), 32'd0);

      // reset in LOW_CHK with cnt=2 on the N=4 instance
      din = 1'b1;
      repeat (4) tick();
      check("busy_before_reset[N=4]", 32'(busy[1]), 32'd1);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check("midreset_dout", 32'(dout), 32'd0);
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_rise", 32'(rise), 32'd0);
      check("midreset_fall", 32'(fall), 32'd0);
      repeat (3) tick();
      #1;
      rst = 1'b1;
      measure(1'b1, "post_reset_press");

      // random bouncing
      v = 1'b0;
      for (int s = 0; s < 10000; s++) begin
         v = ~v;
         if ($urandom_range(0, 199) == 0) len = $urandom_range(250, 262);
         else                             len = $urandom_range(1, 6);
         drive(v, len);
      end
      drive(1'b0, 300);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
